// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing (a - b) mod 2^WIDTH, LSB first,
// one bit per clock, using the full-subtractor cell with a registered borrow.
// Handshake: start accepted in IDLE, busy during RUN, one-cycle done pulse.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output `ovf` and the two operand sign flip-flops it needs.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;      // result shift register (internal only)
  logic [WIDTH-1:0] diff_q, diff_d;  // output register, loaded on last bit
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bq_q, bq_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             ovf_q, ovf_d;
`endif

  logic x_bit, y_bit, d_bit, bq_next, last_bit;

  // Next-state logic: FSM sequencing plus one full-subtractor step per RUN cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bq_d     = bq_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    ovf_d    = ovf_q;
`endif

    x_bit    = sa_q[0];
    y_bit    = sb_q[0];
    d_bit    = x_bit ^ y_bit ^ bq_q;
    bq_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bq_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          cnt_d   = '0;
          bq_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = {d_bit, sr_q[WIDTH-1:1]};
        bq_d  = bq_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = S_DONE;
          diff_d   = {d_bit, sr_q[WIDTH-1:1]};
          borrow_d = bq_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (sign_a_q != sign_b_q) && (d_bit != sign_a_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; all registers here are plain flops, so all are reset.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bq_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bq_q     <= bq_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH=8). Directed cases
// plus randomized operands, compared against an arithmetic reference model.
// Build with SERIAL_SUB_OVF_EN defined to also check the overflow output.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
  logic         ovf_obs;

  int checks = 0;
  int errors = 0;

  // Expected held outputs from the most recent completed operation.
  logic [W-1:0] held_diff = '0;
  logic         held_borrow = 1'b0;
  logic         held_ovf = 1'b0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf_obs),
`endif
    .borrow (borrow)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] md, output logic mbo,
                                output logic mov);
    int ua, ub, sa, sb, r;
    ua  = int'(ma);
    ub  = int'(mb);
    md  = W'(ua - ub + (1 << W));
    mbo = (ua < ub);
    sa  = ma[W-1] ? ua - (1 << W) : ua;
    sb  = mb[W-1] ? ub - (1 << W) : ub;
    r   = sa - sb;
    mov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(held_diff));
    check({tag, "_borrow"}, 32'(borrow), 32'(held_borrow));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf_obs), 32'(held_ovf));
`endif
  endtask

  // Runs one operation from IDLE (called just after a rising edge). When inject
  // is set, a second start with other operands is pulsed 3 cycles into RUN.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit inject);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(ta, tb_v, ed, eb, eo);
    start = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;                       // E0 accepted
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check_held("run_hold");
      a = W'($urandom);
      b = W'($urandom);
      start = inject && (i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    held_diff = ed;
    held_borrow = eb;
    held_ovf = eo;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check_held("result");
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int last_done;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_held("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(8'h35, 8'h12, 1'b0);
    do_op(8'h12, 8'h35, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_held("idle_hold");
      check("idle_hold_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);

    // Start pulsed mid-RUN is ignored; do_op verifies a single done and the
    // original operands' result.
    do_op(8'h5C, 8'h27, 1'b1);

    // Randomized operands.
    for (int n = 0; n < 24; n++) begin
      do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Start held high: back-to-back operations, done every W+2 cycles.
    begin
      logic [W-1:0] ed;
      logic         eb, eo;
      a = 8'hC3;
      b = 8'h4E;
      model(a, b, ed, eb, eo);
      start = 1'b1;
      done_cnt = 0;
      last_done = 0;
      for (int cyc = 1; cyc <= 60 && done_cnt < 3; cyc++) begin
        @(posedge clk); #1;
        if (done) begin
          check("held_diff", 32'(diff), 32'(ed));
          check("held_borrow", 32'(borrow), 32'(eb));
          if (done_cnt > 0) check("held_period", 32'(cyc - last_done), 32'(W + 2));
          last_done = cyc;
          done_cnt++;
        end
      end
      start = 1'b0;
      check("held_done_count", 32'(done_cnt), 32'd3);
      held_diff = ed;
      held_borrow = eb;
      held_ovf = eo;
      @(posedge clk); #1;
      check("held_end_idle", 32'(busy | done), 32'd0);
    end

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    held_diff = '0;
    held_borrow = 1'b0;
    held_ovf = 1'b0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check_held("arst");
    done_cnt = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk);
      if (cyc == 2) begin
        #4;
        rst_n = 1'b1;
      end
      #1;
      if (done) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    check("arst_idle_busy", 32'(busy), 32'd0);
    do_op(8'h35, 8'h12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
